// File: rtl/fcims_order_ctrl_if.sv
// Order/config/response bundle for the food-court inventory order controller.
// The master drives orders and configuration; the slave is the controller.
interface fcims_order_ctrl_if #(
  parameter int N_ITEMS = 4,
  parameter int CNT_W   = 4,
  parameter int PRICE_W = 4,
  parameter int TOT_W   = CNT_W + PRICE_W,
  parameter int IDX_W   = $clog2(N_ITEMS)
);
  logic               req_valid;
  logic               req_ready;
  logic [IDX_W-1:0]   req_item;
  logic [CNT_W-1:0]   req_qty;
  logic               req_ret;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_item;
  logic [PRICE_W-1:0] cfg_price;
  logic [CNT_W-1:0]   cfg_stock;
  logic               rsp_valid;
  logic [1:0]         rsp_err;
  logic [TOT_W-1:0]   rsp_price;
  logic [CNT_W-1:0]   rsp_stock;
  logic [TOT_W-1:0]   total;
  logic               busy;

  modport master (
    output req_valid, req_item, req_qty, req_ret,
    output cfg_we, cfg_item, cfg_price, cfg_stock,
    input  req_ready, rsp_valid, rsp_err, rsp_price, rsp_stock, total, busy
  );

  modport slave (
    input  req_valid, req_item, req_qty, req_ret,
    input  cfg_we, cfg_item, cfg_price, cfg_stock,
    output req_ready, rsp_valid, rsp_err, rsp_price, rsp_stock, total, busy
  );
endinterface

// File: rtl/fcims_order_ctrl.sv
// Buy/return order sequencer: per-item price/stock table, shift-add multiplier,
// stock and running-total limit checks, commit on success, one response per order.
//
// state   | meaning
// IDLE    | waiting for an order; configuration writes accepted here only
// LOAD    | fetch price/stock of the latched item into operand registers
// MUL     | one shift-add step per cycle, qty LSB first
// CHECK   | evaluate faults; commit stock/total on exit when no fault
// RESP    | rsp_valid pulse, then back to IDLE
module fcims_order_ctrl #(
  parameter int N_ITEMS = 4,
  parameter int CNT_W   = 4,
  parameter int PRICE_W = 4,
  parameter int TOT_W   = CNT_W + PRICE_W,
  parameter int IDX_W   = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               reset,
  fcims_order_ctrl_if.slave  bus
);
  localparam int STEP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_CHECK, S_RESP} state_t;

  state_t             state;
  logic [PRICE_W-1:0] price_mem [N_ITEMS];
  logic [CNT_W-1:0]   stock_mem [N_ITEMS];
  logic [IDX_W-1:0]   item_q;
  logic [CNT_W-1:0]   qty_q;
  logic               ret_q;
  logic [CNT_W-1:0]   mplier;
  logic [TOT_W-1:0]   mcand;
  logic [TOT_W-1:0]   prod;
  logic [CNT_W-1:0]   stock_op;
  logic [STEP_W-1:0]  step;
  logic [TOT_W-1:0]   total_q;
  logic               rsp_valid_q;
  logic [1:0]         rsp_err_q;
  logic [TOT_W-1:0]   rsp_price_q;
  logic [CNT_W-1:0]   rsp_stock_q;
  logic               busy_q;

  logic [1:0]         err;
  logic [CNT_W-1:0]   stock_new;
  logic [TOT_W-1:0]   total_new;
  logic [TOT_W:0]     total_sum;
  logic [CNT_W:0]     stock_sum;

  assign total_sum = {1'b0, total_q} + {1'b0, prod};
  assign stock_sum = {1'b0, stock_op} + {1'b0, qty_q};

  // Carry bits of the widened sums flag the upper-limit faults; no value ever wraps.
  always_comb begin
    err       = 2'd0;
    stock_new = stock_op;
    total_new = total_q;
    if (!ret_q) begin
      if (qty_q > stock_op)       err = 2'd1;
      else if (total_sum[TOT_W])  err = 2'd2;
      stock_new = stock_op - qty_q;
      total_new = total_sum[TOT_W-1:0];
    end else begin
      if (stock_sum[CNT_W])       err = 2'd1;
      else if (prod > total_q)    err = 2'd2;
      stock_new = stock_sum[CNT_W-1:0];
      total_new = total_q - prod;
    end
  end

  assign bus.req_ready = (state == S_IDLE) & ~bus.cfg_we & ~reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_price = rsp_price_q;
  assign bus.rsp_stock = rsp_stock_q;
  assign bus.total     = total_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      for (int i = 0; i < N_ITEMS; i++) begin
        price_mem[i] <= '0;
        stock_mem[i] <= '0;
      end
      item_q      <= '0;
      qty_q       <= '0;
      ret_q       <= 1'b0;
      mplier      <= '0;
      mcand       <= '0;
      prod        <= '0;
      stock_op    <= '0;
      step        <= '0;
      total_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 2'd0;
      rsp_price_q <= '0;
      rsp_stock_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.cfg_we) begin
            price_mem[bus.cfg_item] <= bus.cfg_price;
            stock_mem[bus.cfg_item] <= bus.cfg_stock;
          end else if (bus.req_valid) begin
            item_q <= bus.req_item;
            qty_q  <= bus.req_qty;
            ret_q  <= bus.req_ret;
            busy_q <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          mcand    <= {{(TOT_W-PRICE_W){1'b0}}, price_mem[item_q]};
          stock_op <= stock_mem[item_q];
          mplier   <= qty_q;
          prod     <= '0;
          step     <= '0;
          state    <= S_MUL;
        end
        S_MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + 1'b1;
          if (step == LAST_STEP) state <= S_CHECK;
        end
        S_CHECK: begin
          if (err == 2'd0) begin
            stock_mem[item_q] <= stock_new;
            total_q           <= total_new;
            rsp_stock_q       <= stock_new;
          end else begin
            rsp_stock_q       <= stock_op;
          end
          rsp_err_q   <= err;
          rsp_price_q <= prod;
          rsp_valid_q <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fcims_order_ctrl.sv
// Self-checking bench for fcims_order_ctrl: directed scenarios plus random orders
// compared against an arithmetic model of the price/stock table and running total.
module tb_fcims_order_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fcims_order_ctrl_if ifc ();
  fcims_order_ctrl dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc;
  int m_price [4];
  int m_stock [4];
  int m_total;
  int p_item, p_qty, p_ret;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_price[i] = 0;
      m_stock[i] = 0;
    end
    m_total = 0;
  endtask

  task automatic do_cfg(input int item, input int price, input int stock);
    @(negedge clk);
    ifc.cfg_we = 1'b1; ifc.cfg_item = 2'(item);
    ifc.cfg_price = 4'(price); ifc.cfg_stock = 4'(stock);
    @(negedge clk);
    ifc.cfg_we = 1'b0;
    m_price[item] = price;
    m_stock[item] = stock;
  endtask

  task automatic start_order(input int item, input int qty, input int ret);
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_item = 2'(item);
    ifc.req_qty = 4'(qty); ifc.req_ret = ret[0];
    p_item = item; p_qty = qty; p_ret = ret;
    check("ready_before_accept", int'(ifc.req_ready), 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    ifc.req_valid = 1'b0;
    check("busy_after_accept", int'(ifc.busy), 1);
  endtask

  task automatic finish_order(input string tag);
    int prod, st, e, lat;
    prod = p_qty * m_price[p_item];
    st   = m_stock[p_item];
    e    = 0;
    if (p_ret == 0) begin
      if (p_qty > st)                e = 1;
      else if (m_total + prod > 255) e = 2;
      else begin st = st - p_qty; m_total = m_total + prod; end
    end else begin
      if (st + p_qty > 15)           e = 1;
      else if (prod > m_total)       e = 2;
      else begin st = st + p_qty; m_total = m_total - prod; end
    end
    m_stock[p_item] = st;
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ifc.rsp_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    check({tag, "_latency"}, lat, 6);
    check({tag, "_err"},     int'(ifc.rsp_err),   e);
    check({tag, "_price"},   int'(ifc.rsp_price), prod);
    check({tag, "_stock"},   int'(ifc.rsp_stock), st);
    check({tag, "_total"},   int'(ifc.total),     m_total);
    @(posedge clk); #1;
    check({tag, "_pulse"},   int'(ifc.rsp_valid), 0);
    check({tag, "_ready"},   int'(ifc.req_ready), 1);
    check({tag, "_err_hold"}, int'(ifc.rsp_err),  e);
  endtask

  task automatic order(input string tag, input int item, input int qty, input int ret);
    start_order(item, qty, ret);
    finish_order(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", int'(ifc.req_ready), 0);
    check("rst_busy",  int'(ifc.busy), 0);
    check("rst_valid", int'(ifc.rsp_valid), 0);
    check("rst_total", int'(ifc.total), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    ifc.req_valid = 1'b0; ifc.req_item = '0; ifc.req_qty = '0; ifc.req_ret = 1'b0;
    ifc.cfg_we = 1'b0; ifc.cfg_item = '0; ifc.cfg_price = '0; ifc.cfg_stock = '0;
    model_reset();
    #2;
    check("init_ready", int'(ifc.req_ready), 0);
    check("init_err",   int'(ifc.rsp_err), 0);
    check("init_price", int'(ifc.rsp_price), 0);
    check("init_stock", int'(ifc.rsp_stock), 0);
    check("init_busy",  int'(ifc.busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // T1..T3
    do_cfg(1, 5, 10);
    order("t1_buy", 1, 3, 0);
    order("t2_overbuy", 1, 8, 0);
    order("t2_return", 1, 2, 1);
    do_cfg(2, 15, 0);
    order("t3_underflow", 2, 1, 1);
    do_cfg(3, 0, 15);
    order("t3_stock_full", 3, 1, 1);
    order("qty_zero", 1, 0, 0);

    // T4
    apply_reset();
    do_cfg(0, 15, 15);
    order("t4_max", 0, 15, 0);
    do_cfg(1, 15, 15);
    order("t4_overflow", 1, 3, 0);

    // T5: reset while the multiplier is running
    do_cfg(1, 7, 5);
    start_order(1, 2, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t5_busy",  int'(ifc.busy), 0);
    check("t5_ready", int'(ifc.req_ready), 0);
    check("t5_total", int'(ifc.total), 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("t5_no_rsp", int'(ifc.rsp_valid), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("t5_ready_release", int'(ifc.req_ready), 1);
    order("t5_stock_cleared", 1, 1, 0);

    // T6: cfg while busy is ignored; cfg beats a same-cycle request
    do_cfg(2, 3, 4);
    start_order(2, 1, 0);
    @(negedge clk);
    ifc.cfg_we = 1'b1; ifc.cfg_item = 2'd2; ifc.cfg_price = 4'd9; ifc.cfg_stock = 4'd9;
    @(negedge clk);
    ifc.cfg_we = 1'b0;
    finish_order("t6_busy_cfg");
    order("t6_busy_cfg_again", 2, 1, 0);
    @(negedge clk);
    ifc.cfg_we = 1'b1; ifc.cfg_item = 2'd3; ifc.cfg_price = 4'd2; ifc.cfg_stock = 4'd6;
    ifc.req_valid = 1'b1; ifc.req_item = 2'd3; ifc.req_qty = 4'd2; ifc.req_ret = 1'b0;
    p_item = 3; p_qty = 2; p_ret = 0;
    #1;
    check("t6_ready_cfg", int'(ifc.req_ready), 0);
    @(posedge clk); #1;
    check("t6_not_accepted", int'(ifc.busy), 0);
    ifc.cfg_we = 1'b0;
    m_price[3] = 2; m_stock[3] = 6;
    #1;
    check("t6_ready_next", int'(ifc.req_ready), 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    ifc.req_valid = 1'b0;
    finish_order("t6_deferred");

    // random traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      else
        order("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
